// File: rtl/photon_time_tagger_if.sv
// Timestamp stream from one detector channel to its g2 consumer.
// The master side (the tagger) drives ts/ts_v; the consumer answers with ts_r.
interface photon_time_tagger_if #(
  parameter int TS_W = 32
);
  logic [TS_W-1:0] ts;
  logic            ts_v;
  logic            ts_r;

  modport master (output ts, output ts_v, input ts_r);
  modport slave  (input ts, input ts_v, output ts_r);
endinterface

// File: rtl/photon_time_tagger.sv
// Time tagger for one detector channel: the pulse is synchronised and edge-detected,
// then gated by a dead-time filter, and each accepted event is stored with the free-running count.
module photon_time_tagger #(
  parameter int TS_W     = 32,
  parameter int FIFO_AW  = 4,
  parameter int DEAD_CYC = 4,
  parameter int DROP_W   = 16
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  en,
  input  logic                  det_in,
  photon_time_tagger_if.master  out_if,
  output logic [FIFO_AW:0]      fifo_lvl,
  output logic [DROP_W-1:0]     drop_cnt
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int DW    = $clog2(DEAD_CYC + 1);
  localparam logic [DW-1:0]    DEAD_LOAD = DW'(DEAD_CYC - 1);
  localparam logic [FIFO_AW:0] FULL_LVL  = (FIFO_AW + 1)'(DEPTH);

  logic                s1_q, s2_q, s3_q;
  logic [TS_W-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]       dead_q, dead_d;
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    lvl_q, lvl_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [TS_W-1:0]     mem [DEPTH];

  logic evt, full, push, drop, pop;

  assign evt  = s2_q & ~s3_q & en & (dead_q == '0);
  // Fullness is taken from the registered level, so a pop in the same cycle cannot free a slot.
  assign full = (lvl_q == FULL_LVL);
  assign push = evt & ~full;
  assign drop = evt & full;
  assign pop  = (lvl_q != '0) & out_if.ts_r;

  always_comb begin
    cnt_d    = en ? cnt_q + TS_W'(1) : cnt_q;
    dead_d   = dead_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lvl_d    = lvl_q;
    drop_d   = drop_q;

    if (evt)
      dead_d = DEAD_LOAD;
    else if (dead_q != '0)
      dead_d = dead_q - DW'(1);

    if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);

    case ({push, pop})
      2'b10:   lvl_d = lvl_q + (FIFO_AW + 1)'(1);
      2'b01:   lvl_d = lvl_q - (FIFO_AW + 1)'(1);
      default: lvl_d = lvl_q;
    endcase

    if (drop && (drop_q != '1))
      drop_d = drop_q + DROP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      cnt_q    <= '0;
      dead_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
      drop_q   <= '0;
    end else begin
      s1_q     <= det_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      cnt_q    <= cnt_d;
      dead_q   <= dead_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lvl_q    <= lvl_d;
      drop_q   <= drop_d;
    end
  end

  // Storage carries no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_q] <= cnt_q;
  end

  assign out_if.ts   = mem[rd_ptr_q];
  assign out_if.ts_v = (lvl_q != '0);
  assign fifo_lvl    = lvl_q;
  assign drop_cnt    = drop_q;

endmodule
